// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator (master) and its consumers (slave).
// Carries the pixel enable/pause controls in and the sync, enable, position, strobe and frame outputs.
interface vga_timing_gen_if #(
    parameter int HPOS_W  = 10,
    parameter int VPOS_W  = 10,
    parameter int FRAME_W = 12
);
    logic               pix_ce;
    logic               pause_n;
    logic               hsync;
    logic               vsync;
    logic               de;
    logic [HPOS_W-1:0]  hpos;
    logic [VPOS_W-1:0]  vpos;
    logic               line_start;
    logic               frame_start;
    logic [FRAME_W-1:0] frame_cnt;

    modport master (
        input  pix_ce, pause_n,
        output hsync, vsync, de, hpos, vpos, line_start, frame_start, frame_cnt
    );

    modport slave (
        output pix_ce, pause_n,
        input  hsync, vsync, de, hpos, vpos, line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: syncs, display enable, pixel coordinates, line/frame strobes.
// The animation frame counter and its pause control exist only when VGA_TIMING_FRAMECNT_EN is defined.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int HPOS_W     = 10,
    parameter int VPOS_W     = 10,
    parameter int FRAME_W    = 12
) (
    input  logic             clk48,
    input  logic             rst,
    vga_timing_gen_if.master vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HPOS_W-1:0] H_LAST   = HPOS_W'(H_TOTAL - 1);
    localparam logic [HPOS_W-1:0] H_ACT    = HPOS_W'(H_ACTIVE);
    localparam logic [HPOS_W-1:0] HS_FIRST = HPOS_W'(H_ACTIVE + H_FP);
    localparam logic [HPOS_W-1:0] HS_LAST  = HPOS_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VPOS_W-1:0] V_LAST   = VPOS_W'(V_TOTAL - 1);
    localparam logic [VPOS_W-1:0] V_ACT    = VPOS_W'(V_ACTIVE);
    localparam logic [VPOS_W-1:0] VS_FIRST = VPOS_W'(V_ACTIVE + V_FP);
    localparam logic [VPOS_W-1:0] VS_LAST  = VPOS_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [HPOS_W-1:0] hpos_q, hpos_d;
    logic [VPOS_W-1:0] vpos_q, vpos_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic              de_q, de_d;
    logic              line_start_q, line_start_d;
    logic              frame_start_q, frame_start_d;

    // Syncs and DE are decoded from the next position so they leave the
    // register stage aligned with the coordinates they describe.
    always_comb begin
        hpos_d        = hpos_q;
        vpos_d        = vpos_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (vif.pix_ce) begin
            if (hpos_q == H_LAST) begin
                hpos_d        = '0;
                vpos_d        = (vpos_q == V_LAST) ? '0 : vpos_q + VPOS_W'(1);
                line_start_d  = 1'b1;
                frame_start_d = (vpos_q == V_LAST);
            end else begin
                hpos_d = hpos_q + HPOS_W'(1);
            end
        end
        de_d    = (hpos_d < H_ACT) && (vpos_d < V_ACT);
        hsync_d = ((hpos_d >= HS_FIRST) && (hpos_d <= HS_LAST)) ? H_SYNC_POL : ~H_SYNC_POL;
        vsync_d = ((vpos_d >= VS_FIRST) && (vpos_d <= VS_LAST)) ? V_SYNC_POL : ~V_SYNC_POL;
    end

    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            hpos_q        <= H_LAST;
            vpos_q        <= V_LAST;
            hsync_q       <= ~H_SYNC_POL;
            vsync_q       <= ~V_SYNC_POL;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vif.hpos        = hpos_q;
    assign vif.vpos        = vpos_q;
    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.de          = de_q;
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAMECNT_EN
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

    // Counts entries into vertical blanking; the reset->(0,0) step never lands on V_ACTIVE.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (line_start_d && (vpos_d == V_ACT) && vif.pause_n) begin
            frame_cnt_d = frame_cnt_q + FRAME_W'(1);
        end
    end

    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign vif.frame_cnt = frame_cnt_q;
`else
    logic unused_pause_n;

    assign unused_pause_n = vif.pause_n;
    assign vif.frame_cnt  = {FRAME_W{1'b0}};
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: a reduced-geometry instance against a linear-index raster model,
// plus a full 640x480 instance checked over its first lines with closed-form arithmetic.
module tb_vga_timing_gen;
    // Reduced geometry: H 16+2+4+3 = 25, V 12+2+2+3 = 19, frame = 475 clocks
    localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
    localparam int VA = 12, VFP = 2, VS = 2, VBP = 3;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FT = HT * VT;
    localparam int FC_MOD = 16;
`ifdef VGA_TIMING_FRAMECNT_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif

    logic clk48 = 1'b0;
    logic rst   = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk48 = ~clk48;

    vga_timing_gen_if #(.HPOS_W(5), .VPOS_W(5), .FRAME_W(4)) vs ();
    vga_timing_gen_if vb ();

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0),
        .HPOS_W(5), .VPOS_W(5), .FRAME_W(4)
    ) dut_s (
        .clk48(clk48),
        .rst  (rst),
        .vif  (vs)
    );

    vga_timing_gen dut_b (
        .clk48(clk48),
        .rst  (rst_b),
        .vif  (vb)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: k = number of pixel advances since reset; k=0 is the (HT-1, VT-1) reset position.
    int k = 0;
    int fc_m = 0;
    int mh = HT - 1, mv = VT - 1;
    bit mls = 1'b0, mfs = 1'b0;

    task automatic model_pos();
        int p;
        p  = ((k % FT) + FT - 1) % FT;
        mh = p % HT;
        mv = p / HT;
    endtask

    task automatic model_reset();
        k = 0; fc_m = 0; mls = 1'b0; mfs = 1'b0;
        model_pos();
    endtask

    task automatic model_edge(input bit pce, input bit pn);
        mls = 1'b0;
        mfs = 1'b0;
        if (pce) begin
            k++;
            model_pos();
            mls = (mh == 0);
            mfs = (mh == 0) && (mv == 0);
            if (FC_EN && mh == 0 && mv == VA && pn) fc_m = (fc_m + 1) % FC_MOD;
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".hpos"},        int'(vs.hpos), mh);
        chk({tag, ".vpos"},        int'(vs.vpos), mv);
        chk({tag, ".de"},          int'(vs.de), int'(mh < HA && mv < VA));
        chk({tag, ".hsync"},       int'(vs.hsync), int'(mh >= HA + HFP && mh < HA + HFP + HS));
        chk({tag, ".vsync"},       int'(vs.vsync), int'(!(mv >= VA + VFP && mv < VA + VFP + VS)));
        chk({tag, ".line_start"},  int'(vs.line_start), int'(mls));
        chk({tag, ".frame_start"}, int'(vs.frame_start), int'(mfs));
        chk({tag, ".frame_cnt"},   int'(vs.frame_cnt), fc_m);
    endtask

    task automatic step(input bit pce, input bit pn, input string tag);
        vs.pix_ce  = pce;
        vs.pause_n = pn;
        @(posedge clk48);
        model_edge(pce, pn);
        #1;
        compare_all(tag);
    endtask

    typedef struct {
        bit pce;
        int h;
        int v;
        bit de;
        bit ls;
        bit fs;
    } vec_t;

    vec_t tbl[6];

    initial begin
        bit pn;
        int guard;
        int p, h, v;
        int fc_before;

        tbl[0] = '{pce: 1'b1, h: 0, v: 0, de: 1'b1, ls: 1'b1, fs: 1'b1};
        tbl[1] = '{pce: 1'b0, h: 0, v: 0, de: 1'b1, ls: 1'b0, fs: 1'b0};
        tbl[2] = '{pce: 1'b1, h: 1, v: 0, de: 1'b1, ls: 1'b0, fs: 1'b0};
        tbl[3] = '{pce: 1'b1, h: 2, v: 0, de: 1'b1, ls: 1'b0, fs: 1'b0};
        tbl[4] = '{pce: 1'b0, h: 2, v: 0, de: 1'b1, ls: 1'b0, fs: 1'b0};
        tbl[5] = '{pce: 1'b1, h: 3, v: 0, de: 1'b1, ls: 1'b0, fs: 1'b0};

        vs.pix_ce  = 1'b1;
        vs.pause_n = 1'b1;
        vb.pix_ce  = 1'b1;
        vb.pause_n = 1'b1;
        model_reset();

        // Reset state with pix_ce high must not move the raster
        repeat (3) @(posedge clk48);
        #1;
        compare_all("reset");
        chk("reset.hpos_abs", int'(vs.hpos), HT - 1);
        chk("reset.vpos_abs", int'(vs.vpos), VT - 1);
        $display("reset state checked: hpos=%0d vpos=%0d", vs.hpos, vs.vpos);
        rst = 1'b0;

        // Table: first advances after reset release, with a 1/0 pix_ce pattern
        for (int i = 0; i < 6; i++) begin
            vs.pix_ce = tbl[i].pce;
            @(posedge clk48);
            model_edge(tbl[i].pce, 1'b1);
            #1;
            chk("tbl.hpos", int'(vs.hpos), tbl[i].h);
            chk("tbl.vpos", int'(vs.vpos), tbl[i].v);
            chk("tbl.de", int'(vs.de), int'(tbl[i].de));
            chk("tbl.line_start", int'(vs.line_start), int'(tbl[i].ls));
            chk("tbl.frame_start", int'(vs.frame_start), int'(tbl[i].fs));
            $display("vec %0d: pix_ce=%0d hpos=%0d vpos=%0d de=%0d ls=%0d fs=%0d",
                     i, tbl[i].pce, vs.hpos, vs.vpos, vs.de, vs.line_start, vs.frame_start);
        end

        // Randomized pix_ce and slowly toggling pause_n against the model
        pn = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 599) == 0) pn = ~pn;
            step($urandom_range(0, 3) != 0, pn, "rand");
        end
        $display("random phase done: advances=%0d frame_cnt=%0d", k, vs.frame_cnt);

        // pix_ce held low: everything frozen, strobes low
        for (int i = 0; i < 50; i++) step(1'b0, 1'b1, "freeze");
        $display("freeze 50 clks done: hpos=%0d vpos=%0d", vs.hpos, vs.vpos);

        // Paused across two vblank starts, then enough frames to wrap the counter
        fc_before = fc_m;
        for (int i = 0; i < 2 * FT + 5; i++) step(1'b1, 1'b0, "pause");
        chk("pause.frame_cnt_held", int'(vs.frame_cnt), fc_before);
        $display("pause across two vblanks done: frame_cnt=%0d", vs.frame_cnt);
        for (int i = 0; i < (FC_MOD + 1) * FT; i++) step(1'b1, 1'b1, "run");
        chk("wrap.frame_cnt", int'(vs.frame_cnt), FC_EN ? (fc_before + FC_MOD + 1) % FC_MOD : 0);
        $display("run of %0d frames done: frame_cnt=%0d", FC_MOD + 1, vs.frame_cnt);

        // Asynchronous reset mid-frame, then restart
        guard = 0;
        while (!(mh == 10 && mv == 5) && guard < 2 * FT) begin
            step(1'b1, 1'b1, "seek");
            guard++;
        end
        chk("seek.reached", int'(mh == 10 && mv == 5), 1);
        rst = 1'b1;
        #2;
        model_reset();
        compare_all("async_rst");
        @(posedge clk48);
        #1;
        compare_all("rst_held");
        rst = 1'b0;
        step(1'b1, 1'b1, "restart");
        chk("restart.frame_start", int'(vs.frame_start), 1);
        $display("mid-frame reset and restart done: hpos=%0d vpos=%0d fs=%0d",
                 vs.hpos, vs.vpos, vs.frame_start);

        // Full-size geometry: first lines of a 640x480 raster
        #1;
        chk("big.rst_hpos", int'(vb.hpos), 799);
        chk("big.rst_vpos", int'(vb.vpos), 524);
        chk("big.rst_hsync", int'(vb.hsync), 1);
        chk("big.rst_de", int'(vb.de), 0);
        rst_b = 1'b0;
        for (int n = 1; n <= 1700; n++) begin
            @(posedge clk48);
            #1;
            p = n - 1;
            h = p % 800;
            v = (p / 800) % 525;
            chk("big.hpos", int'(vb.hpos), h);
            chk("big.vpos", int'(vb.vpos), v);
            chk("big.de", int'(vb.de), int'(h < 640 && v < 480));
            chk("big.hsync", int'(vb.hsync), int'(!(h >= 656 && h <= 751)));
            chk("big.vsync", int'(vb.vsync), 1);
            chk("big.line_start", int'(vb.line_start), int'(h == 0));
            chk("big.frame_start", int'(vb.frame_start), int'(h == 0 && v == 0));
            chk("big.frame_cnt", int'(vb.frame_cnt), 0);
        end
        $display("full-size line scan done: hpos=%0d vpos=%0d", vb.hpos, vb.vpos);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
